// File: rtl/music_pkg.sv
// Shared constants and types for the music player voice allocation path.
package music_pkg;

  localparam int NUM_VOICES_DEF = 3;
  localparam int NOTE_W_DEF     = 6;
  localparam int DUR_W_DEF      = 6;

  // Note code that means "silence"; such entries never occupy a voice.
  localparam int REST_NOTE      = 0;

  typedef enum logic [0:0] {
    ACCEPT = 1'b0,
    WAIT   = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/voice_select.sv
// Combinational pick of the voice that receives the next note: lowest free
// voice, otherwise the voice closest to finishing (lowest index on a tie).
module voice_select #(
  parameter int NUM_VOICES = 3,
  parameter int DUR_W      = 6,
  parameter int IDX_W      = 2
) (
  input  logic [NUM_VOICES*DUR_W-1:0] remaining,
  output logic [IDX_W-1:0]            target,
  output logic                        all_busy
);

  logic             free_found_s;
  logic [IDX_W-1:0] free_idx_s;
  logic [IDX_W-1:0] min_idx_s;
  logic [DUR_W-1:0] min_val_s;

  // Scan for the first idle voice and, in parallel, the least-remaining voice.
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = {IDX_W{1'b0}};
    min_idx_s    = {IDX_W{1'b0}};
    min_val_s    = remaining[0 +: DUR_W];
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!free_found_s && (remaining[i*DUR_W +: DUR_W] == {DUR_W{1'b0}})) begin
        free_found_s = 1'b1;
        free_idx_s   = IDX_W'(i);
      end else begin
        free_found_s = free_found_s;
      end
    end
    // Strict less-than keeps the lower index when counts tie.
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (remaining[i*DUR_W +: DUR_W] < min_val_s) begin
        min_val_s = remaining[i*DUR_W +: DUR_W];
        min_idx_s = IDX_W'(i);
      end else begin
        min_val_s = min_val_s;
      end
    end
    all_busy = !free_found_s;
    if (free_found_s) begin
      target = free_idx_s;
    end else begin
      target = min_idx_s;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Assigns song entries to note_player voices, tracks per-voice remaining
// beats, and stalls the song stream while a wait entry counts down.
module voice_allocator
  import music_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int NOTE_W     = NOTE_W_DEF,
  parameter int DUR_W      = DUR_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         play,
  input  logic                         flush,
  input  logic                         beat,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_is_wait,
  input  logic [NOTE_W-1:0]            in_note,
  input  logic [DUR_W-1:0]             in_duration,
  output logic [NUM_VOICES-1:0]        voice_load,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic                         stalled
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  alloc_state_e                 state_r;
  alloc_state_e                 state_next_s;
  logic [DUR_W-1:0]             wait_r;
  logic [NUM_VOICES*DUR_W-1:0]  remaining_r;
  logic [NUM_VOICES*NOTE_W-1:0] voice_note_r;
  logic [NUM_VOICES-1:0]        voice_load_r;
  logic [IDX_W-1:0]             target_s;
  logic                         all_busy_s;
  logic                         clear_s;
  logic                         tick_s;
  logic                         accept_s;
  logic                         load_s;
  logic                         wait_start_s;
  logic                         in_ready_s;
  logic                         stalled_s;

  // Reset and flush are interchangeable clears.
  assign clear_s      = reset | flush;
  // Beats only count while playing; a pause freezes every counter.
  assign tick_s       = beat & play;
  // Built from state directly rather than in_ready to keep the FSM acyclic.
  assign accept_s     = in_valid & play & (state_r == ACCEPT);
  assign load_s       = accept_s & ~in_is_wait
                      & (in_note != NOTE_W'(REST_NOTE))
                      & (in_duration != {DUR_W{1'b0}});
  assign wait_start_s = accept_s & in_is_wait & (in_duration != {DUR_W{1'b0}});

  assign in_ready   = in_ready_s;
  assign stalled    = stalled_s;
  assign voice_load = voice_load_r;
  assign voice_note = voice_note_r;

  voice_select #(
    .NUM_VOICES (NUM_VOICES),
    .DUR_W      (DUR_W),
    .IDX_W      (IDX_W)
  ) u_voice_select (
    .remaining (remaining_r),
    .target    (target_s),
    .all_busy  (all_busy_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (clear_s) begin
      state_r <= ACCEPT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state and handshake outputs; a wait ends on the beat that empties it.
  always_comb begin
    state_next_s = state_r;
    in_ready_s   = 1'b0;
    stalled_s    = 1'b0;
    case (state_r)
      ACCEPT: begin
        in_ready_s = play;
        if (wait_start_s) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = ACCEPT;
        end
      end
      WAIT: begin
        stalled_s = 1'b1;
        if (tick_s && (wait_r <= DUR_W'(1))) begin
          state_next_s = ACCEPT;
        end else begin
          state_next_s = WAIT;
        end
      end
      default: begin
        state_next_s = ACCEPT;
      end
    endcase
  end

  // Wait counter: loaded on a nonzero wait entry, counts beats down to zero.
  always_ff @(posedge clk) begin
    if (clear_s) begin
      wait_r <= {DUR_W{1'b0}};
    end else if (wait_start_s) begin
      wait_r <= in_duration;
    end else if ((state_r == WAIT) && tick_s && (wait_r != {DUR_W{1'b0}})) begin
      wait_r <= wait_r - DUR_W'(1);
    end else begin
      wait_r <= wait_r;
    end
  end

  // Per-voice note, remaining count and load pulse; a load beats a decrement.
  always_ff @(posedge clk) begin
    if (clear_s) begin
      remaining_r  <= {(NUM_VOICES*DUR_W){1'b0}};
      voice_note_r <= {(NUM_VOICES*NOTE_W){1'b0}};
      voice_load_r <= {NUM_VOICES{1'b0}};
    end else begin
      voice_load_r <= {NUM_VOICES{1'b0}};
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (load_s && (target_s == IDX_W'(i))) begin
          remaining_r[i*DUR_W +: DUR_W]   <= in_duration;
          voice_note_r[i*NOTE_W +: NOTE_W] <= in_note;
          voice_load_r[i]                 <= 1'b1;
        end else if (tick_s && (remaining_r[i*DUR_W +: DUR_W] != {DUR_W{1'b0}})) begin
          remaining_r[i*DUR_W +: DUR_W] <= remaining_r[i*DUR_W +: DUR_W] - DUR_W'(1);
        end else begin
          remaining_r[i*DUR_W +: DUR_W] <= remaining_r[i*DUR_W +: DUR_W];
        end
      end
    end
  end

  // A voice sounds while it still has beats left.
  always_comb begin
    voice_active = {NUM_VOICES{1'b0}};
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_active[i] = (remaining_r[i*DUR_W +: DUR_W] != {DUR_W{1'b0}});
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator.
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        play = 1'b0;
  logic        flush = 1'b0;
  logic        beat = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_is_wait = 1'b0;
  logic [5:0]  in_note = 6'd0;
  logic [5:0]  in_duration = 6'd0;
  logic [2:0]  voice_load;
  logic [17:0] voice_note;
  logic [2:0]  voice_active;
  logic        stalled;

  int n_checks = 0;
  int n_fail   = 0;

  voice_allocator dut (
    .clk          (clk),
    .reset        (reset),
    .play         (play),
    .flush        (flush),
    .beat         (beat),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_is_wait   (in_is_wait),
    .in_note      (in_note),
    .in_duration  (in_duration),
    .voice_load   (voice_load),
    .voice_note   (voice_note),
    .voice_active (voice_active),
    .stalled      (stalled)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic w, input logic [5:0] note, input logic [5:0] dur);
    in_valid = 1'b1; in_is_wait = w; in_note = note; in_duration = dur;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_is_wait = 1'b0; in_note = 6'd0; in_duration = 6'd0;
  endtask

  task automatic do_beat();
    beat = 1'b1;
    cyc();
    beat = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; play = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    n_checks++; if (voice_load !== 3'b000) begin n_fail++; $display("FAIL reset_load got %b exp 000", voice_load); end
    n_checks++; if (voice_note !== 18'd0) begin n_fail++; $display("FAIL reset_note got %h exp 0", voice_note); end
    n_checks++; if (voice_active !== 3'b000) begin n_fail++; $display("FAIL reset_active got %b exp 000", voice_active); end
    n_checks++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL reset_stalled got %b exp 0", stalled); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_paused got %b exp 0", in_ready); end
    play = 1'b1; #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_play got %b exp 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    offer(1'b0, 6'd10, 6'd4); cyc();
    n_checks++; if (voice_load !== 3'b001) begin n_fail++; $display("FAIL b2b_load0 got %b exp 001", voice_load); end
    offer(1'b0, 6'd20, 6'd4); cyc();
    n_checks++; if (voice_load !== 3'b010) begin n_fail++; $display("FAIL b2b_load1 got %b exp 010", voice_load); end
    offer(1'b0, 6'd30, 6'd4); cyc();
    n_checks++; if (voice_load !== 3'b100) begin n_fail++; $display("FAIL b2b_load2 got %b exp 100", voice_load); end
    idle(); cyc();
    n_checks++; if (voice_load !== 3'b000) begin n_fail++; $display("FAIL b2b_load_end got %b exp 000", voice_load); end
    n_checks++; if (voice_note !== {6'd30, 6'd20, 6'd10}) begin n_fail++; $display("FAIL b2b_note got %h exp %h", voice_note, {6'd30, 6'd20, 6'd10}); end
    n_checks++; if (voice_active !== 3'b111) begin n_fail++; $display("FAIL b2b_active got %b exp 111", voice_active); end
  endtask

  task automatic test_wait();
    offer(1'b1, 6'd0, 6'd4); cyc(); idle();
    n_checks++; if (stalled !== 1'b1) begin n_fail++; $display("FAIL wait_stalled got %b exp 1", stalled); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL wait_ready got %b exp 0", in_ready); end
    for (int b = 1; b <= 4; b++) begin
      repeat (499) cyc();
      do_beat();
      if (b < 4) begin
        n_checks++; if (stalled !== 1'b1 || voice_active !== 3'b111) begin n_fail++; $display("FAIL wait_mid beat %0d got stalled=%b active=%b exp 1/111", b, stalled, voice_active); end
      end else begin
        n_checks++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL wait_end_stalled got %b exp 0", stalled); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL wait_end_ready got %b exp 1", in_ready); end
        n_checks++; if (voice_active !== 3'b000) begin n_fail++; $display("FAIL wait_end_active got %b exp 000", voice_active); end
      end
    end
  endtask

  task automatic test_steal_and_pause();
    offer(1'b0, 6'd1, 6'd2); cyc();
    offer(1'b0, 6'd2, 6'd2); cyc();
    offer(1'b0, 6'd3, 6'd5); cyc();
    n_checks++; if (voice_active !== 3'b111) begin n_fail++; $display("FAIL steal_busy got %b exp 111", voice_active); end
    offer(1'b0, 6'd40, 6'd3); cyc(); idle();
    n_checks++; if (voice_load !== 3'b001) begin n_fail++; $display("FAIL steal_load got %b exp 001", voice_load); end
    n_checks++; if (voice_note !== {6'd3, 6'd2, 6'd40}) begin n_fail++; $display("FAIL steal_note got %h exp %h", voice_note, {6'd3, 6'd2, 6'd40}); end
    // remaining now {5,2,3}
    do_beat(); // {4,1,2}
    do_beat(); // {3,0,1}
    n_checks++; if (voice_active !== 3'b101) begin n_fail++; $display("FAIL steal_beat2 got %b exp 101", voice_active); end
    do_beat(); // {2,0,0}
    n_checks++; if (voice_active !== 3'b100) begin n_fail++; $display("FAIL steal_beat3 got %b exp 100", voice_active); end
    // Wait of 2 while voice 2 has 2 beats left, then pause across 3 beats.
    offer(1'b1, 6'd0, 6'd2); cyc(); idle();
    play = 1'b0;
    repeat (3) begin cyc(); do_beat(); end
    n_checks++; if (voice_active !== 3'b100) begin n_fail++; $display("FAIL pause_active got %b exp 100", voice_active); end
    n_checks++; if (stalled !== 1'b1) begin n_fail++; $display("FAIL pause_stalled got %b exp 1", stalled); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL pause_ready got %b exp 0", in_ready); end
    play = 1'b1;
    do_beat();
    n_checks++; if (voice_active !== 3'b100 || stalled !== 1'b1) begin n_fail++; $display("FAIL resume_beat1 got active=%b stalled=%b exp 100/1", voice_active, stalled); end
    do_beat();
    n_checks++; if (voice_active !== 3'b000 || stalled !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL resume_beat2 got active=%b stalled=%b ready=%b exp 000/0/1", voice_active, stalled, in_ready); end
  endtask

  task automatic test_consumed();
    logic [5:0] note_tab [3];
    logic [5:0] dur_tab  [3];
    logic       wait_tab [3];
    note_tab = '{6'd0, 6'd12, 6'd0};
    dur_tab  = '{6'd5, 6'd0, 6'd0};
    wait_tab = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL consume_ready %0d got %b exp 1", k, in_ready); end
      offer(wait_tab[k], note_tab[k], dur_tab[k]); cyc();
      n_checks++; if (voice_load !== 3'b000 || stalled !== 1'b0 || voice_active !== 3'b000) begin n_fail++; $display("FAIL consume_%0d got load=%b stalled=%b active=%b exp 000/0/000", k, voice_load, stalled, voice_active); end
    end
    idle(); cyc();
    n_checks++; if (voice_note !== {6'd3, 6'd2, 6'd40}) begin n_fail++; $display("FAIL consume_note_hold got %h exp %h", voice_note, {6'd3, 6'd2, 6'd40}); end
  endtask

  task automatic test_flush_and_collide();
    offer(1'b0, 6'd7, 6'd3); cyc();
    offer(1'b1, 6'd0, 6'd5); cyc(); idle();
    n_checks++; if (stalled !== 1'b1 || voice_active !== 3'b001) begin n_fail++; $display("FAIL preflush got stalled=%b active=%b exp 1/001", stalled, voice_active); end
    flush = 1'b1; cyc(); flush = 1'b0;
    n_checks++; if (stalled !== 1'b0 || voice_active !== 3'b000 || voice_note !== 18'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush got stalled=%b active=%b note=%h ready=%b exp 0/000/0/1", stalled, voice_active, voice_note, in_ready); end
    // Fill all voices with {4,3,2}, then load a busy voice during a beat.
    offer(1'b0, 6'd1, 6'd2); cyc();
    offer(1'b0, 6'd2, 6'd3); cyc();
    offer(1'b0, 6'd3, 6'd4); cyc();
    offer(1'b0, 6'd50, 6'd3); beat = 1'b1; cyc(); beat = 1'b0; idle();
    n_checks++; if (voice_load !== 3'b001 || voice_note[5:0] !== 6'd50) begin n_fail++; $display("FAIL collide_load got load=%b note0=%0d exp 001/50", voice_load, voice_note[5:0]); end
    // remaining now {3,2,3}
    do_beat(); // {2,1,2}
    do_beat(); // {1,0,1}
    n_checks++; if (voice_active !== 3'b101) begin n_fail++; $display("FAIL collide_beat2 got %b exp 101", voice_active); end
    do_beat(); // {0,0,0}
    n_checks++; if (voice_active !== 3'b000) begin n_fail++; $display("FAIL collide_beat3 got %b exp 000", voice_active); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wait();
    test_steal_and_pause();
    test_consumed();
    test_flush_and_collide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
